// File: rtl/word_serializer.sv
// Parallel-in / serial-out serializer: captures a DEPTH x WIDTH word on load and
// presents it on SS one slice per enable, lowest slice first.
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] PE,
    output logic [WIDTH-1:0]       SS,
    output logic                   busy,
    output logic                   last,
    output logic                   ovr,
    output logic                   dbg_state
);

    // Handshake: busy is the valid for SS; enable is the consumer's accept.
    // A slice is transferred on every clk edge where busy and enable are both high.
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state, state_nxt;
    logic [DEPTH*WIDTH-1:0]   storage, storage_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     ovr_nxt;

    assign SS        = storage[WIDTH-1:0];
    assign busy      = (state == SHIFT);
    assign last      = busy && (cnt == CW'(DEPTH - 1));
    assign dbg_state = (state == SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            storage <= '0;
            cnt     <= '0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            storage <= storage_nxt;
            cnt     <= cnt_nxt;
            ovr     <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        storage_nxt = storage;
        cnt_nxt     = cnt;
        ovr_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    storage_nxt = PE;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (enable && last) begin
                    // Final slice consumed: a load here chains the next word with no bubble.
                    cnt_nxt = '0;
                    if (load) begin
                        storage_nxt = PE;
                    end else begin
                        storage_nxt = '0;
                        state_nxt   = IDLE;
                    end
                end else begin
                    if (enable) begin
                        storage_nxt = {{WIDTH{1'b0}}, storage[DEPTH*WIDTH-1:WIDTH]};
                        cnt_nxt     = cnt + CW'(1);
                    end
                    if (load) begin
                        ovr_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
